// File: rtl/pwm_pkg.sv
// Shared PWM definitions: capture FSM states and the default counter width
// used by the PWM timer, comparator and capture blocks.
package pwm_pkg;

  localparam int PWM_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

endpackage

// File: rtl/pwm_sync_edge.sv
// PWM_IN synchronizer (SYNC_STAGES flops) plus a delay flop for edge detect.
// o_s lags i_pwm by SYNC_STAGES edges; o_rise/o_fall are combinational from o_s and its delayed copy.
module pwm_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pwm,
  output logic o_s,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pwm};
      r_s_d  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_s    = r_sync[SYNC_STAGES-1];
  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_s_d;
  assign o_fall = ~r_sync[SYNC_STAGES-1] & r_s_d;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of PWM_IN in clock cycles, with stuck-input timeout.
// VALID is registered one edge after the synchronized rise (SYNC_STAGES+1 edges after PWM_IN rises).
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int WIDTH       = PWM_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENABLE,
  input  logic             PWM_IN,
  input  logic [WIDTH-1:0] TIMEOUT,
  output logic [WIDTH-1:0] PERIOD_OUT,
  output logic [WIDTH-1:0] HIGH_OUT,
  output logic             VALID,
  output logic             STUCK,
  output logic             LEVEL,
  output logic             OVF
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic w_s, w_rise, w_fall;

  pwm_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk (CLK),
    .i_rst (RST),
    .i_pwm (PWM_IN),
    .o_s   (w_s),
    .o_rise(w_rise),
    .o_fall(w_fall)
  );

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_per_cnt, w_per_nxt;
  logic [WIDTH-1:0] r_high_cnt, w_high_nxt;
  logic [WIDTH-1:0] r_hold, w_hold_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             w_meas, w_stuck;

  logic             w_per_sat, w_high_sat;
  logic [WIDTH-1:0] w_per_inc, w_high_inc;
  logic             w_to_arm, w_to_run;

  assign w_per_sat  = (r_per_cnt == CNT_MAX);
  assign w_high_sat = (r_high_cnt == CNT_MAX);
  assign w_per_inc  = w_per_sat ? CNT_MAX : r_per_cnt + CNT_ONE;
  assign w_high_inc = w_high_sat ? CNT_MAX : r_high_cnt + CNT_ONE;

  // ARM's idle counter restarts from 0 after a report, so it fires one count
  // earlier to keep repeated stuck reports exactly TIMEOUT cycles apart.
  assign w_to_arm = (TIMEOUT != '0) && (r_per_cnt == TIMEOUT - CNT_ONE);
  assign w_to_run = (TIMEOUT != '0) && (r_per_cnt == TIMEOUT);

  always_comb begin
    w_state_nxt = r_state;
    w_per_nxt   = r_per_cnt;
    w_high_nxt  = r_high_cnt;
    w_hold_nxt  = r_hold;
    w_ovf_nxt   = r_ovf;
    w_meas      = 1'b0;
    w_stuck     = 1'b0;
    if (!ENABLE) begin
      w_state_nxt = IDLE;
      w_per_nxt   = '0;
      w_high_nxt  = '0;
      w_hold_nxt  = '0;
      w_ovf_nxt   = 1'b0;
    end else begin
      case (r_state)
        IDLE: w_state_nxt = ARM;
        ARM: begin
          if (w_rise) begin
            w_per_nxt   = CNT_ONE;
            w_high_nxt  = CNT_ONE;
            w_ovf_nxt   = 1'b0;
            w_state_nxt = HIGH;
          end else if (w_to_arm) begin
            w_stuck = 1'b1;
          end else begin
            w_per_nxt = w_per_inc;
          end
        end
        HIGH: begin
          if (w_to_run) begin
            w_stuck = 1'b1;
          end else begin
            w_per_nxt  = w_per_inc;
            w_high_nxt = w_high_inc;
            w_ovf_nxt  = r_ovf | w_per_sat | w_high_sat;
            if (w_fall) begin
              w_hold_nxt  = r_high_cnt;
              w_state_nxt = LOW;
            end
          end
        end
        LOW: begin
          if (w_rise) begin
            w_meas      = 1'b1;
            w_per_nxt   = CNT_ONE;
            w_high_nxt  = CNT_ONE;
            w_ovf_nxt   = 1'b0;
            w_state_nxt = HIGH;
          end else if (w_to_run) begin
            w_stuck = 1'b1;
          end else begin
            w_per_nxt = w_per_inc;
            w_ovf_nxt = r_ovf | w_per_sat;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
      if (w_stuck) begin
        w_state_nxt = ARM;
        w_per_nxt   = '0;
        w_high_nxt  = '0;
        w_ovf_nxt   = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= IDLE;
      r_per_cnt  <= '0;
      r_high_cnt <= '0;
      r_hold     <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_per_cnt  <= w_per_nxt;
      r_high_cnt <= w_high_nxt;
      r_hold     <= w_hold_nxt;
      r_ovf      <= w_ovf_nxt;
    end
  end

  logic [WIDTH-1:0] r_period_out, r_high_out;
  logic             r_valid, r_stuck, r_level, r_ovf_out;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_period_out <= '0;
      r_high_out   <= '0;
      r_valid      <= 1'b0;
      r_stuck      <= 1'b0;
      r_level      <= 1'b0;
      r_ovf_out    <= 1'b0;
    end else begin
      r_valid <= w_meas | w_stuck;
      if (w_meas) begin
        r_period_out <= r_per_cnt;
        r_high_out   <= r_hold;
        r_stuck      <= 1'b0;
        r_ovf_out    <= r_ovf;
      end else if (w_stuck) begin
        r_period_out <= '0;
        r_high_out   <= '0;
        r_stuck      <= 1'b1;
        r_level      <= w_s;
        r_ovf_out    <= 1'b0;
      end
    end
  end

  assign PERIOD_OUT = r_period_out;
  assign HIGH_OUT   = r_high_out;
  assign VALID      = r_valid;
  assign STUCK      = r_stuck;
  assign LEVEL      = r_level;
  assign OVF        = r_ovf_out;

endmodule
